// File: rtl/lsu.sv
// Load/store unit: one word-aligned valid/ready bus transaction per request,
// returning the lane-extracted load result or a misalignment fault to writeback.
module lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_store,
  input  logic [2:0]       in_funct3,
  input  logic [WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0] in_wdata,
  input  logic [4:0]       in_rd,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic             out_fault
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t           state, state_next;
  logic             op_store;
  logic [2:0]       op_funct3;
  logic [1:0]       op_lane;
  logic             accept;
  logic             fault;
  logic [WIDTH-1:0] wdata_enc;
  logic [3:0]       wstrb_enc;
  logic [7:0]       lbyte;
  logic [15:0]      lhalf;
  logic [WIDTH-1:0] load_val;

  assign in_ready  = (state == IDLE);
  assign mem_valid = (state == BUS);
  assign mem_we    = (state == BUS) && op_store;
  assign out_valid = (state == RESP);
  assign accept    = in_valid && in_ready;

  // Stores only support B/H/W; loads additionally allow BU/HU.
  always_comb begin
    fault = 1'b0;
    case (in_funct3)
      3'd0:    fault = 1'b0;
      3'd1:    fault = in_addr[0];
      3'd2:    fault = (in_addr[1:0] != 2'b00);
      3'd4:    fault = in_store;
      3'd5:    fault = in_store || in_addr[0];
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    wdata_enc = '0;
    wstrb_enc = '0;
    if (in_store) begin
      case (in_funct3[1:0])
        2'd0: begin
          wdata_enc = {4{in_wdata[7:0]}};
          wstrb_enc = 4'b0001 << in_addr[1:0];
        end
        2'd1: begin
          wdata_enc = {2{in_wdata[15:0]}};
          wstrb_enc = 4'b0011 << {in_addr[1], 1'b0};
        end
        default: begin
          wdata_enc = in_wdata;
          wstrb_enc = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    case (op_lane)
      2'd0:    lbyte = mem_rdata[7:0];
      2'd1:    lbyte = mem_rdata[15:8];
      2'd2:    lbyte = mem_rdata[23:16];
      default: lbyte = mem_rdata[31:24];
    endcase
    lhalf = op_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_funct3)
      3'd0:    load_val = {{(WIDTH-8){lbyte[7]}}, lbyte};
      3'd1:    load_val = {{(WIDTH-16){lhalf[15]}}, lhalf};
      3'd4:    load_val = {{(WIDTH-8){1'b0}}, lbyte};
      3'd5:    load_val = {{(WIDTH-16){1'b0}}, lhalf};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = fault ? RESP : BUS;
      BUS:     if (mem_ready) state_next = RESP;
      RESP:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_store  <= 1'b0;
      op_funct3 <= '0;
      op_lane   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      out_data  <= '0;
      out_rd    <= '0;
      out_wen   <= 1'b0;
      out_fault <= 1'b0;
    end else begin
      if (accept) begin
        op_store  <= in_store;
        op_funct3 <= in_funct3;
        op_lane   <= in_addr[1:0];
        mem_addr  <= {in_addr[WIDTH-1:2], 2'b00};
        mem_wdata <= wdata_enc;
        mem_wstrb <= wstrb_enc;
        out_rd    <= in_rd;
        out_fault <= fault;
        out_data  <= '0;
        out_wen   <= 1'b0;
      end
      if (state == BUS && mem_ready) begin
        out_data <= op_store ? '0 : load_val;
        out_wen  <= !op_store && (out_rd != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a byte-level model predicts bus and writeback values,
// and one per-cycle compare task checks the DUT against it.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_fault;

  lsu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wen(out_wen), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // expected handshake levels for the current cycle
  bit exp_in_ready, exp_mem_valid, exp_out_valid;
  // model prediction for the current op
  bit          exp_fault, exp_we, exp_wen;
  logic [31:0] exp_addr, exp_wdata, exp_out_data;
  logic [3:0]  exp_wstrb;
  logic [4:0]  exp_rd;
  // last values seen on the DUT, for literal spot checks
  logic [31:0] last_out_data, last_mem_addr, last_mem_wdata;
  logic [3:0]  last_mem_wstrb;
  int          mem_valid_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Byte-level reference: sizes, lanes and extension from the ISA rules.
  task automatic predict(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdata, input logic [4:0] rd);
    int unsigned size, lane;
    bit legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (f3 <= 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
    lane  = a % 4;
    exp_fault = !legal || (lane % size != 0);
    exp_addr  = a - lane;
    exp_we    = st;
    exp_rd    = rd;
    exp_wstrb = '0;
    exp_wdata = '0;
    exp_out_data = '0;
    exp_wen   = 1'b0;
    if (st) begin
      for (int i = 0; i < 4; i++) begin
        exp_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
        if (i >= lane && i < lane + size) exp_wstrb[i] = 1'b1;
      end
    end else if (!exp_fault) begin
      v = '0;
      for (int k = 0; k < size; k++) v[8*k +: 8] = rdata[8*(lane + k) +: 8];
      if (!f3[2] && size < 4 && v[8*size - 1]) v = v | (32'hFFFF_FFFF << (8*size));
      exp_out_data = v;
      exp_wen = (rd != 5'd0);
    end
  endtask

  task automatic compare();
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready});
    chk("mem_valid", {31'b0, mem_valid}, {31'b0, exp_mem_valid});
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_out_valid});
    if (mem_valid) mem_valid_seen++;
    if (exp_mem_valid) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
      chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_wstrb});
      if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      last_mem_addr  = mem_addr;
      last_mem_wdata = mem_wdata;
      last_mem_wstrb = mem_wstrb;
    end
    if (exp_out_valid) begin
      chk("out_data", out_data, exp_out_data);
      chk("out_rd", {27'b0, out_rd}, {27'b0, exp_rd});
      chk("out_wen", {31'b0, out_wen}, {31'b0, exp_wen});
      chk("out_fault", {31'b0, out_fault}, {31'b0, exp_fault});
      last_out_data = out_data;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                        input int bw, input int rw, input bit stray);
    predict(st, f3, a, wd, rdata, rd);
    mem_valid_seen = 0;
    in_valid = 1'b1; in_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd; in_rd = rd;
    @(negedge clk);
    if (stray) begin
      in_store = 1'b1; in_funct3 = 3'd2; in_addr = 32'h80; in_rd = rd ^ 5'h1F;
    end else begin
      in_valid = 1'b0;
    end
    exp_in_ready = 1'b0;
    if (!exp_fault) begin
      exp_mem_valid = 1'b1;
      exp_out_valid = 1'b0;
      for (int i = 0; i < bw; i++) begin
        compare();
        mem_ready = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
      end
      compare();
      mem_ready = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_ready = 1'b0;
    end
    exp_mem_valid = 1'b0;
    exp_out_valid = 1'b1;
    for (int i = 0; i < rw; i++) begin
      compare();
      out_ready = 1'b0;
      @(negedge clk);
    end
    compare();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    exp_out_valid = 1'b0;
    exp_in_ready  = 1'b1;
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_store = 1'b0; in_funct3 = '0; in_addr = '0;
    in_wdata = '0; in_rd = '0; mem_ready = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    exp_in_ready = 1'b1; exp_mem_valid = 1'b0; exp_out_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    compare();
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_rd", {27'b0, out_rd}, 32'h0);
    chk("rst_out_wen", {31'b0, out_wen}, 32'h0);
    chk("rst_out_fault", {31'b0, out_fault}, 32'h0);

    // pin the model against hand-computed values
    predict(1'b0, 3'd0, 32'h1003, 32'h0, 32'h80FF_1234, 5'd5);
    chk("model_lb", exp_out_data, 32'hFFFF_FF80);
    predict(1'b1, 3'd1, 32'h12, 32'h1234, 32'h0, 5'd1);
    chk("model_sh_wdata", exp_wdata, 32'h1234_1234);
    chk("model_sh_wstrb", {28'b0, exp_wstrb}, 32'hC);
    predict(1'b0, 3'd2, 32'h6, 32'h0, 32'h0, 5'd1);
    chk("model_lw_fault", {31'b0, exp_fault}, 32'h1);

    // LB sign-extension from the top lane
    run_op(1'b0, 3'd0, 32'h1003, 32'h0, 5'd5, 32'h80FF_1234, 0, 0, 0);
    chk("lb_addr", last_mem_addr, 32'h1000);
    chk("lb_wstrb", {28'b0, last_mem_wstrb}, 32'h0);
    chk("lb_data", last_out_data, 32'hFFFF_FF80);

    // LHU / LH on the upper half
    run_op(1'b0, 3'd5, 32'h2002, 32'h0, 5'd6, 32'hBEEF_0000, 0, 0, 0);
    chk("lhu_data", last_out_data, 32'h0000_BEEF);
    run_op(1'b0, 3'd1, 32'h2002, 32'h0, 5'd6, 32'hBEEF_0000, 0, 0, 0);
    chk("lh_data", last_out_data, 32'hFFFF_BEEF);

    // stores: lane replication and strobes
    run_op(1'b1, 3'd0, 32'h11, 32'h0000_00A5, 5'd7, 32'h0, 0, 0, 0);
    chk("sb_addr", last_mem_addr, 32'h10);
    chk("sb_wdata", last_mem_wdata, 32'hA5A5_A5A5);
    chk("sb_wstrb", {28'b0, last_mem_wstrb}, 32'h2);
    run_op(1'b1, 3'd1, 32'h12, 32'h0000_1234, 5'd7, 32'h0, 0, 0, 0);
    chk("sh_wdata", last_mem_wdata, 32'h1234_1234);
    chk("sh_wstrb", {28'b0, last_mem_wstrb}, 32'hC);
    run_op(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, 5'd3, 32'h0, 1, 1, 0);

    // faults: no bus request, result one cycle after accept
    run_op(1'b0, 3'd2, 32'h6, 32'h0, 5'd9, 32'h0, 0, 0, 0);
    chk("lw_mis_nobus", mem_valid_seen, 0);
    run_op(1'b1, 3'd1, 32'h5, 32'h1234, 5'd9, 32'h0, 0, 1, 0);
    chk("sh_mis_nobus", mem_valid_seen, 0);
    run_op(1'b0, 3'd3, 32'h0, 32'h0, 5'd9, 32'h0, 0, 0, 0);
    run_op(1'b1, 3'd4, 32'h0, 32'h0, 5'd9, 32'h0, 0, 0, 0);

    // more lanes, rd=0 load still goes to the bus
    run_op(1'b0, 3'd4, 32'h302, 32'h0, 5'd0, 32'h00C3_0000, 0, 0, 0);
    chk("rd0_bus", mem_valid_seen, 1);
    run_op(1'b0, 3'd0, 32'h301, 32'h0, 5'd4, 32'h0000_7F00, 0, 0, 0);

    // mem_ready while idle is ignored
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    compare();

    // backpressure on both sides with a stray request held upstream
    run_op(1'b0, 3'd2, 32'h40, 32'h0, 5'd10, 32'h1357_9BDF, 3, 2, 1);
    chk("bp_data", last_out_data, 32'h1357_9BDF);
    @(negedge clk);
    compare();

    // reset mid-BUS abandons the transaction
    predict(1'b0, 3'd2, 32'h40, 32'h0, 32'h0, 5'd11);
    in_valid = 1'b1; in_store = 1'b0; in_funct3 = 3'd2; in_addr = 32'h40; in_rd = 5'd11;
    @(negedge clk);
    in_valid = 1'b0;
    exp_in_ready = 1'b0; exp_mem_valid = 1'b1;
    compare();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    exp_in_ready = 1'b1; exp_mem_valid = 1'b0; exp_out_valid = 1'b0;
    compare();
    @(negedge clk);
    mem_ready = 1'b0;
    compare();
    repeat (2) begin
      @(negedge clk);
      compare();
    end

    // reset in RESP discards the result
    predict(1'b0, 3'd2, 32'h4, 32'h0, 32'h0, 5'd12);
    in_valid = 1'b1; in_store = 1'b0; in_funct3 = 3'd2; in_addr = 32'h4; in_rd = 5'd12;
    @(negedge clk);
    in_valid = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h2468_ACE0;
    @(negedge clk);
    mem_ready = 1'b0;
    exp_in_ready = 1'b0; exp_out_valid = 1'b1; exp_out_data = 32'h2468_ACE0; exp_wen = 1'b1;
    compare();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_in_ready = 1'b1; exp_out_valid = 1'b0;
    compare();
    chk("rst_resp_wen", {31'b0, out_wen}, 32'h0);
    chk("rst_resp_data", out_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit directly downstream of the ALU in the execute path. It takes the ALU's arith_out as the effective address and rb as the store data. It runs one word-aligned memory transaction over a valid/ready bus, then returns the lane-extracted, sign- or zero-extended load result, or a misalignment fault, to writeback. One operation is in flight at a time.

Parameters:
WIDTH, 32, data/address width; 32 is the only supported value (byte-lane logic assumes 4 lanes).

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
in_store  input  1  1 = store, 0 = load
in_funct3  input  3  RV32I width/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
in_addr  input  WIDTH  effective address (ALU arith_out)
in_wdata  input  WIDTH  store data (rb)
in_rd  input  5  destination register tag
mem_valid  output  1  bus request valid
mem_ready  input  1  bus accepts/completes request this cycle
mem_we  output  1  write enable
mem_addr  output  WIDTH  word address, {in_addr[31:2],2'b00}
mem_wdata  output  WIDTH  lane-replicated store data
mem_wstrb  output  4  byte strobes
mem_rdata  input  WIDTH  read data; valid in the cycle mem_valid&&mem_ready
out_valid  output  1  result valid
out_ready  input  1  writeback accepts result
out_data  output  WIDTH  load result (0 for stores and faults)
out_rd  output  5  tag of completed op
out_wen  output  1  register write: load, no fault, rd!=0
out_fault  output  1  misaligned address or illegal funct3

Behaviour:
- FSM states IDLE, BUS, RESP. in_ready = (state==IDLE).
- Accept when in_valid && in_ready. Latch store flag, funct3, addr[1:0], rd, mem_addr, mem_wdata and mem_wstrb.
- Fault check at accept:
  - H/HU with addr[0]=1 -> fault; W with addr[1:0]!=0 -> fault.
  - Load funct3 in {3,6,7} -> fault; store funct3 >= 3 -> fault.
  - On fault: go IDLE->RESP directly. No bus request. out_fault=1, out_data=0, out_wen=0.
- Otherwise IDLE->BUS.
- BUS: mem_valid=1, mem_we=store. mem_addr, mem_wdata, mem_wstrb and mem_we stay stable until mem_ready. No timeout.
- Leaving BUS: on mem_ready, go BUS->RESP.
  - Load: capture lane of mem_rdata selected by addr[1:0], extended per funct3 (B/H sign-extend, BU/HU zero-extend, W whole word).
  - Store: out_data=0.
- Store encoding:
  - SB: wdata={4{b[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{h[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=in_wdata, wstrb=4'b1111.
  - Loads drive wstrb=0 and mem_we=0.
- RESP: out_valid=1 with out_data/out_rd/out_wen/out_fault stable until out_ready; on out_ready go RESP->IDLE.
- Latency, for a request accepted at edge N:
  - mem_valid high in cycle N+1.
  - mem_ready in that cycle -> out_valid in cycle N+2.
  - out_ready in that cycle -> in_ready in cycle N+3.
  - Minimum throughput: one op per 3 cycles; a fault op takes 2 cycles.
- in_valid is ignored while not IDLE; upstream must hold the request until accepted.
- rd=0 load: bus access still performed; out_wen=0.
- Reset (rst_n low at an edge): state IDLE. mem_valid, mem_we, mem_wstrb, out_valid, out_wen and out_fault go to 0. mem_addr, mem_wdata, out_data and out_rd go to 0. in_ready=1 after the edge.
  - Reset mid-BUS abandons the transaction; mem_valid is 0 from the next cycle and a late mem_ready is ignored.
  - Reset in RESP discards the result.
- mem_ready while not in BUS: ignored.

Test Plan:
1. LB addr=0x1003, mem_rdata=0x80FF_1234, mem_ready in first BUS cycle -> mem_addr=0x1000, wstrb=0; out_data=0xFFFF_FF80, out_wen=1, out_valid 2 cycles after accept.
2. LHU addr=0x2002, rdata=0xBEEF_0000 -> out_data=0x0000_BEEF. The same access as LH -> 0xFFFF_BEEF.
3. SB addr=0x11, wdata=0x0000_00A5 -> mem_we=1, mem_addr=0x10, mem_wdata=0xA5A5_A5A5, wstrb=4'b0010. Then SH addr=0x12, wdata=0x1234 -> wdata=0x1234_1234, wstrb=4'b1100. Both: out_wen=0.
4. LW addr=0x6, and separately SH addr=0x5 -> mem_valid never asserts; out_fault=1, out_wen=0, out_valid 1 cycle after accept.
5. Backpressure: LW addr=0x40 with mem_ready held low 3 cycles, then out_ready low 2 cycles -> bus signals stable throughout; in_ready low until the cycle after out_ready; a second in_valid during that time is not accepted.
6. Reset mid-BUS: rst_n=0 for one edge while mem_valid=1, then mem_ready pulsed -> mem_valid=0, out_valid never asserts, in_ready=1.
